// File: rtl/rf_access_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rf_access_arbiter_if : one requester's request/response bundle
// Revision: 1.0
// ----------------------------------------------------------------------------
interface rf_access_arbiter_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      req;
  logic                      we;
  logic [REG_ADDR_WIDTH-1:0] addr_r1;
  logic [REG_ADDR_WIDTH-1:0] addr_r2;
  logic [REG_ADDR_WIDTH-1:0] addr_w;
  logic [DATA_WIDTH-1:0]     data_w;
  logic                      ack;
  logic [DATA_WIDTH-1:0]     data_r1;
  logic [DATA_WIDTH-1:0]     data_r2;

  modport master (
    output req, we, addr_r1, addr_r2, addr_w, data_w,
    input  ack, data_r1, data_r2
  );

  modport slave (
    input  req, we, addr_r1, addr_r2, addr_w, data_w,
    output ack, data_r1, data_r2
  );
endinterface
`default_nettype wire

// File: rtl/rf_access_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rf_access_arbiter : arbitrates two requesters onto one register-file port.
// Optional RF_ARB_RR_EN: round-robin on simultaneous requests (else A wins).
// Revision: 1.0
// ----------------------------------------------------------------------------
module rf_access_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      CLK,
  input  logic                      RST,
  rf_access_arbiter_if.slave        a_port,
  rf_access_arbiter_if.slave        b_port,
  output logic                      RF_READ,
  output logic                      RF_WRITE,
  output logic [REG_ADDR_WIDTH-1:0] RF_ADDR_R1,
  output logic [REG_ADDR_WIDTH-1:0] RF_ADDR_R2,
  output logic [REG_ADDR_WIDTH-1:0] RF_ADDR_W,
  output logic [DATA_WIDTH-1:0]     RF_DATA_W,
  input  logic [DATA_WIDTH-1:0]     RF_DATA_R1,
  input  logic [DATA_WIDTH-1:0]     RF_DATA_R2,
  output logic                      BUSY
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RD_ISSUE   = 3'd1,
    S_RD_CAPTURE = 3'd2,
    S_WR_ISSUE   = 3'd3,
    S_RESP       = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic                      gnt_b_q, gnt_b_d;
  logic                      rf_read_q, rf_read_d;
  logic                      rf_write_q, rf_write_d;
  logic [REG_ADDR_WIDTH-1:0] addr_r1_q, addr_r1_d;
  logic [REG_ADDR_WIDTH-1:0] addr_r2_q, addr_r2_d;
  logic [REG_ADDR_WIDTH-1:0] addr_w_q, addr_w_d;
  logic [DATA_WIDTH-1:0]     data_w_q, data_w_d;
  logic                      a_ack_q, a_ack_d;
  logic                      b_ack_q, b_ack_d;
  logic [DATA_WIDTH-1:0]     a_data_r1_q, a_data_r1_d;
  logic [DATA_WIDTH-1:0]     a_data_r2_q, a_data_r2_d;
  logic [DATA_WIDTH-1:0]     b_data_r1_q, b_data_r1_d;
  logic [DATA_WIDTH-1:0]     b_data_r2_q, b_data_r2_d;
  logic                      pick_b;
  logic                      grant_we;
`ifdef RF_ARB_RR_EN
  logic                      last_b_q, last_b_d;
`endif

  always_comb begin
    state_d     = state_q;
    gnt_b_d     = gnt_b_q;
    rf_read_d   = 1'b0;
    rf_write_d  = 1'b0;
    addr_r1_d   = addr_r1_q;
    addr_r2_d   = addr_r2_q;
    addr_w_d    = addr_w_q;
    data_w_d    = data_w_q;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    a_data_r1_d = a_data_r1_q;
    a_data_r2_d = a_data_r2_q;
    b_data_r1_d = b_data_r1_q;
    b_data_r2_d = b_data_r2_q;
    pick_b      = 1'b0;
    grant_we    = 1'b0;
`ifdef RF_ARB_RR_EN
    last_b_d    = last_b_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (a_port.req || b_port.req) begin
`ifdef RF_ARB_RR_EN
          // On contention the port that did not win last time goes first.
          pick_b   = b_port.req && (!a_port.req || !last_b_q);
          last_b_d = pick_b;
`else
          pick_b   = b_port.req && !a_port.req;
`endif
          gnt_b_d    = pick_b;
          grant_we   = pick_b ? b_port.we      : a_port.we;
          addr_r1_d  = pick_b ? b_port.addr_r1 : a_port.addr_r1;
          addr_r2_d  = pick_b ? b_port.addr_r2 : a_port.addr_r2;
          addr_w_d   = pick_b ? b_port.addr_w  : a_port.addr_w;
          data_w_d   = pick_b ? b_port.data_w  : a_port.data_w;
          state_d    = grant_we ? S_WR_ISSUE : S_RD_ISSUE;
          rf_write_d = grant_we;
          rf_read_d  = !grant_we;
        end
      end
      S_RD_ISSUE: begin
        state_d   = S_RD_CAPTURE;
        rf_read_d = 1'b1;
      end
      S_RD_CAPTURE: begin
        // Register-file data is only valid while RF_READ is held here.
        state_d = S_RESP;
        if (gnt_b_q) begin
          b_data_r1_d = RF_DATA_R1;
          b_data_r2_d = RF_DATA_R2;
          b_ack_d     = 1'b1;
        end else begin
          a_data_r1_d = RF_DATA_R1;
          a_data_r2_d = RF_DATA_R2;
          a_ack_d     = 1'b1;
        end
      end
      S_WR_ISSUE: begin
        state_d = S_RESP;
        a_ack_d = !gnt_b_q;
        b_ack_d = gnt_b_q;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      gnt_b_q     <= 1'b0;
      rf_read_q   <= 1'b0;
      rf_write_q  <= 1'b0;
      addr_r1_q   <= '0;
      addr_r2_q   <= '0;
      addr_w_q    <= '0;
      data_w_q    <= '0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      a_data_r1_q <= '0;
      a_data_r2_q <= '0;
      b_data_r1_q <= '0;
      b_data_r2_q <= '0;
`ifdef RF_ARB_RR_EN
      last_b_q    <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      gnt_b_q     <= gnt_b_d;
      rf_read_q   <= rf_read_d;
      rf_write_q  <= rf_write_d;
      addr_r1_q   <= addr_r1_d;
      addr_r2_q   <= addr_r2_d;
      addr_w_q    <= addr_w_d;
      data_w_q    <= data_w_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
      a_data_r1_q <= a_data_r1_d;
      a_data_r2_q <= a_data_r2_d;
      b_data_r1_q <= b_data_r1_d;
      b_data_r2_q <= b_data_r2_d;
`ifdef RF_ARB_RR_EN
      last_b_q    <= last_b_d;
`endif
    end
  end

  assign RF_READ        = rf_read_q;
  assign RF_WRITE       = rf_write_q;
  assign RF_ADDR_R1     = addr_r1_q;
  assign RF_ADDR_R2     = addr_r2_q;
  assign RF_ADDR_W      = addr_w_q;
  assign RF_DATA_W      = data_w_q;
  assign BUSY           = (state_q != S_IDLE);

  assign a_port.ack     = a_ack_q;
  assign a_port.data_r1 = a_data_r1_q;
  assign a_port.data_r2 = a_data_r2_q;
  assign b_port.ack     = b_ack_q;
  assign b_port.data_r1 = b_data_r1_q;
  assign b_port.data_r2 = b_data_r2_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_access_arbiter.sv
`default_nettype none
// tb_rf_access_arbiter : directed vectors plus mixed traffic, checked every
// cycle against a transaction-level model (grant time + fixed latency table).
module tb_rf_access_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          CLK;
  logic          RST;
  logic          RF_READ, RF_WRITE, BUSY;
  logic [AW-1:0] RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W;
  logic [DW-1:0] RF_DATA_W, RF_DATA_R1, RF_DATA_R2;

  rf_access_arbiter_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) a_if ();
  rf_access_arbiter_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) b_if ();

  rf_access_arbiter #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .a_port     (a_if),
    .b_port     (b_if),
    .RF_READ    (RF_READ),
    .RF_WRITE   (RF_WRITE),
    .RF_ADDR_R1 (RF_ADDR_R1),
    .RF_ADDR_R2 (RF_ADDR_R2),
    .RF_ADDR_W  (RF_ADDR_W),
    .RF_DATA_W  (RF_DATA_W),
    .RF_DATA_R1 (RF_DATA_R1),
    .RF_DATA_R2 (RF_DATA_R2),
    .BUSY       (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Stand-in register file; drives garbage when the read strobe is not valid.
  logic [DW-1:0] rf_mem [32];
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
    end else if (RF_WRITE) begin
      rf_mem[RF_ADDR_W] <= RF_DATA_W;
    end
  end
  assign RF_DATA_R1 = (RF_READ && !RF_WRITE) ? rf_mem[RF_ADDR_R1] : 32'hBAD0_0001;
  assign RF_DATA_R2 = (RF_READ && !RF_WRITE) ? rf_mem[RF_ADDR_R2] : 32'hBAD0_0002;

  // Transaction model: a grant occupies m_len cycles (write 2, read 3) and
  // the ack lands in the last one; read data is the memory content at grant.
  logic [DW-1:0] m_mem [32];
  logic [DW-1:0] m_r1 [2];
  logic [DW-1:0] m_r2 [2];
  bit            m_active, m_b, m_we, m_last_b;
  int            m_k, m_len, m_grants;
  logic [AW-1:0] m_a1, m_a2, m_aw;
  logic [DW-1:0] m_dw, m_rd1, m_rd2;

  initial begin
    m_grants = 0;
    forever begin
      @(posedge CLK or negedge RST);
      if (!RST) begin
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        m_r1[0] = '0; m_r1[1] = '0; m_r2[0] = '0; m_r2[1] = '0;
        m_active = 1'b0; m_k = 0; m_len = 0; m_last_b = 1'b1;
        m_b = 1'b0; m_we = 1'b0;
        m_a1 = '0; m_a2 = '0; m_aw = '0; m_dw = '0; m_rd1 = '0; m_rd2 = '0;
      end else if (m_active) begin
        m_k++;
        if (m_k == m_len && !m_we) begin
          m_r1[m_b] = m_rd1;
          m_r2[m_b] = m_rd2;
        end
        if (m_k > m_len) m_active = 1'b0;
      end else if (a_if.req || b_if.req) begin
`ifdef RF_ARB_RR_EN
        if (a_if.req && b_if.req) m_b = !m_last_b;
        else                      m_b = b_if.req;
`else
        m_b = b_if.req && !a_if.req;
`endif
        m_last_b = m_b;
        m_we  = m_b ? b_if.we      : a_if.we;
        m_a1  = m_b ? b_if.addr_r1 : a_if.addr_r1;
        m_a2  = m_b ? b_if.addr_r2 : a_if.addr_r2;
        m_aw  = m_b ? b_if.addr_w  : a_if.addr_w;
        m_dw  = m_b ? b_if.data_w  : a_if.data_w;
        m_len = m_we ? 2 : 3;
        if (m_we) m_mem[m_aw] = m_dw;
        else begin
          m_rd1 = m_mem[m_a1];
          m_rd2 = m_mem[m_a2];
        end
        m_active = 1'b1;
        m_k = 1;
        m_grants++;
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge CLK);
      if (chk_en) begin
        bit e_rd, e_wr, e_ack;
        e_rd  = m_active && !m_we && (m_k <= 2);
        e_wr  = m_active && m_we && (m_k == 1);
        e_ack = m_active && (m_k == m_len);
        chk("busy", BUSY, m_active);
        chk("rf_read", RF_READ, e_rd);
        chk("rf_write", RF_WRITE, e_wr);
        chk("rd_wr_excl", RF_READ & RF_WRITE, 0);
        chk("a_ack", a_if.ack, e_ack && !m_b);
        chk("b_ack", b_if.ack, e_ack && m_b);
        if (e_rd) begin
          chk("rf_addr_r1", RF_ADDR_R1, m_a1);
          chk("rf_addr_r2", RF_ADDR_R2, m_a2);
        end
        if (e_wr) begin
          chk("rf_addr_w", RF_ADDR_W, m_aw);
          chk("rf_data_w", RF_DATA_W, m_dw);
        end
        chk("a_data_r1", a_if.data_r1, m_r1[0]);
        chk("a_data_r2", a_if.data_r2, m_r2[0]);
        chk("b_data_r1", b_if.data_r1, m_r1[1]);
        chk("b_data_r2", b_if.data_r2, m_r2[1]);
      end
    end
  end

  int ack_total = 0;
  initial begin
    forever begin
      @(negedge CLK);
      if (RST) ack_total += int'(a_if.ack) + int'(b_if.ack);
    end
  end

  // One protocol-compliant access; lat is the cycle index of the ack counted
  // from the IDLE cycle in which the request is first sampled (-1 on timeout).
  task automatic xact(input bit pb, input bit we, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                      input logic [AW-1:0] w, input logic [DW-1:0] dw, output int lat);
    if (pb) begin
      b_if.we = we; b_if.addr_r1 = r1; b_if.addr_r2 = r2; b_if.addr_w = w; b_if.data_w = dw; b_if.req = 1'b1;
    end else begin
      a_if.we = we; a_if.addr_r1 = r1; a_if.addr_r2 = r2; a_if.addr_w = w; a_if.data_w = dw; a_if.req = 1'b1;
    end
    lat = -1;
    for (int n = 0; n < 12; n++) begin
      @(negedge CLK);
      if (pb ? b_if.ack : a_if.ack) begin
        lat = n;
        break;
      end
    end
    @(posedge CLK); #1;
    if (pb) b_if.req = 1'b0; else a_if.req = 1'b0;
  endtask

  initial begin
    int lat, a_n, b_n, first, b_got, ack0, gr0;
    bit a_seen, b_seen;
    a_if.req = 0; a_if.we = 0; a_if.addr_r1 = 0; a_if.addr_r2 = 0; a_if.addr_w = 0; a_if.data_w = 0;
    b_if.req = 0; b_if.we = 0; b_if.addr_r1 = 0; b_if.addr_r2 = 0; b_if.addr_w = 0; b_if.data_w = 0;
    RST = 1'b1;
    #2 RST = 1'b0;
    #1 chk_en = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busy", BUSY, 0);
    chk("rst_rf_write", RF_WRITE, 0);
    chk("rst_rf_addr_w", RF_ADDR_W, 0);
    chk("rst_a_data_r1", a_if.data_r1, 0);
    @(negedge CLK); #2 RST = 1'b1;
    @(posedge CLK); #1;

    // Basic write then read on A
    xact(0, 1, 0, 0, 5, 32'hDEADBEEF, lat);
    chk("a_wr_latency", lat, 2);
    xact(0, 0, 5, 0, 0, 0, lat);
    chk("a_rd_latency", lat, 3);
    chk("a_rd_r1", a_if.data_r1, 32'hDEADBEEF);
    chk("a_rd_r2", a_if.data_r2, 32'h0);
    xact(1, 1, 0, 0, 3, 32'h0BADF00D, lat);
    chk("b_wr_latency", lat, 2);

    // Contention: A read (5,7) and B write 7 both held for 12 cycles
    a_if.we = 0; a_if.addr_r1 = 5; a_if.addr_r2 = 7;
    b_if.we = 1; b_if.addr_w = 7; b_if.data_w = 32'h12345678;
    a_if.req = 1; b_if.req = 1;
    a_n = 0; b_n = 0; first = -1;
    for (int n = 0; n < 12; n++) begin
      @(negedge CLK);
      if (a_if.ack) begin a_n++; if (first < 0) first = 0; end
      if (b_if.ack) begin b_n++; if (first < 0) first = 1; end
    end
    #2 a_if.req = 0;
    b_got = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge CLK);
      if (b_if.ack) begin b_got = 1; break; end
    end
    @(posedge CLK); #1;
    b_if.req = 0;
    chk("contend_first_is_a", first, 0);
`ifdef RF_ARB_RR_EN
    chk("contend_a_acks", a_n, 2);
    chk("contend_b_acks", b_n, 1);
`else
    chk("contend_a_acks", a_n, 3);
    chk("contend_b_starved", b_n, 0);
`endif
    chk("contend_b_served", b_got, 1);

    // B reads back; A outputs must stay as they were
    xact(1, 0, 7, 5, 0, 0, lat);
    chk("b_rd_latency", lat, 3);
    chk("b_rd_r1", b_if.data_r1, 32'h12345678);
    chk("b_rd_r2", b_if.data_r2, 32'hDEADBEEF);
    chk("a_kept_r1", a_if.data_r1, 32'hDEADBEEF);
`ifdef RF_ARB_RR_EN
    chk("a_kept_r2", a_if.data_r2, 32'h12345678);
`else
    chk("a_kept_r2", a_if.data_r2, 32'h0);
`endif

    // Reset during RD_CAPTURE
    a_if.we = 0; a_if.addr_r1 = 5; a_if.addr_r2 = 0; a_if.req = 1;
    repeat (3) @(negedge CLK);
    chk("pre_rst_rf_read", RF_READ, 1);
    #2 RST = 1'b0;
    #1;
    chk("midrst_busy", BUSY, 0);
    chk("midrst_rf_read", RF_READ, 0);
    chk("midrst_rf_addr_r1", RF_ADDR_R1, 0);
    chk("midrst_a_ack", a_if.ack, 0);
    chk("midrst_a_data_r1", a_if.data_r1, 0);
    chk("midrst_b_data_r1", b_if.data_r1, 0);
    a_if.req = 0;
    @(negedge CLK); #2 RST = 1'b1;
    @(posedge CLK); #1;
    xact(0, 0, 5, 0, 0, 0, lat);
    chk("post_rst_rd_latency", lat, 3);
    chk("post_rst_rd_r1", a_if.data_r1, 0);

    // Mixed traffic
    ack0 = ack_total; gr0 = m_grants;
    a_seen = 0; b_seen = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge CLK);
      a_seen = a_if.ack; b_seen = b_if.ack;
      @(posedge CLK); #1;
      if (a_if.req && a_seen) a_if.req = 0;
      else if (!a_if.req && $urandom_range(0, 2) == 0) begin
        a_if.we = 1'($urandom_range(0, 1)); a_if.addr_r1 = AW'($urandom_range(0, 7));
        a_if.addr_r2 = AW'($urandom_range(0, 7)); a_if.addr_w = AW'($urandom_range(0, 7));
        a_if.data_w = $urandom; a_if.req = 1;
      end
      if (b_if.req && b_seen) b_if.req = 0;
      else if (!b_if.req && $urandom_range(0, 2) == 0) begin
        b_if.we = 1'($urandom_range(0, 1)); b_if.addr_r1 = AW'($urandom_range(0, 7));
        b_if.addr_r2 = AW'($urandom_range(0, 7)); b_if.addr_w = AW'($urandom_range(0, 7));
        b_if.data_w = $urandom; b_if.req = 1;
      end
    end
    a_if.req = 0; b_if.req = 0;
    repeat (6) @(posedge CLK);
    #1;
    chk("traffic_one_ack_per_grant", ack_total - ack0, m_grants - gr0);
    chk("traffic_some_grants", (m_grants - gr0) > 20, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    miscompares++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
